// File: rtl/apb_slave_regfile.sv
// APB slave exposing DEPTH 8-bit registers. Each transfer inserts WAIT_STATES
// PREADY-low access cycles; out-of-range addresses complete with PSLVERR.
module apb_slave_regfile #(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic       PCLK,
   input  logic       PRESERn,
   input  logic       PSEL1,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t        state_r;
   state_t        state_nxt_s;
   logic [3:0]    cnt_r;
   logic [3:0]    cnt_nxt_s;
   logic          done_s;
   logic          in_range_s;
   logic          wr_en_s;
   logic [AW-1:0] idx_s;
   logic [7:0]    regs_r [DEPTH];

   // Widen to 9 bits so DEPTH = 256 compares correctly.
   function automatic logic addr_in_range(input logic [7:0] addr);
      return ({1'b0, addr} < 9'(DEPTH));
   endfunction

   // Address decode and write strobe for the completing cycle.
   always_comb begin
      in_range_s = addr_in_range(PADDR);
      idx_s      = PADDR[AW-1:0];
      wr_en_s    = done_s & PWRITE & in_range_s;
   end

   // State and wait-counter registers.
   always_ff @(posedge PCLK or negedge PRESERn) begin
      if (!PRESERn) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Next-state logic; PENABLE seen in IDLE is a protocol violation and ignored.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (PSEL1 && !PENABLE) begin
               state_nxt_s = ST_WAIT;
               cnt_nxt_s   = 4'(WAIT_STATES);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!PSEL1) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 4'd0;
            end else if (PENABLE) begin
               if (cnt_r == 4'd0) begin
                  done_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  cnt_nxt_s = cnt_r - 4'd1;
               end
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = 4'd0;
         end
      endcase
   end

   // Register file storage, written at the completing edge.
   always_ff @(posedge PCLK or negedge PRESERn) begin
      if (!PRESERn) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_r[i] <= 8'h00;
         end
      end else if (wr_en_s) begin
         regs_r[idx_s] <= PWDATA;
      end
   end

   // Completion response; outputs are quiet whenever no transfer completes.
   always_comb begin
      PREADY  = done_s;
      PSLVERR = 1'b0;
      PRDATA  = 8'h00;
      if (done_s && !in_range_s) begin
         PSLVERR = 1'b1;
      end else begin
         PSLVERR = 1'b0;
      end
      if (done_s && !PWRITE && in_range_s) begin
         PRDATA = regs_r[idx_s];
      end else begin
         PRDATA = 8'h00;
      end
   end

endmodule
